// File: rtl/gray_stream_checker.sv
// Gray-code stream checker: decodes each accepted sample, checks that it is a legal +1 step
// from the previous one, and tracks lock status and a saturating error count.
module gray_stream_checker #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             locked,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] prev_gray, prev_gray_d;
  logic [CNT_W-1:0] good_cnt, good_cnt_d;
  logic [WIDTH-1:0] bin_out_d;
  logic             bin_valid_d, locked_d, step_err_d;
  logic [ERR_W-1:0] err_count_d;

  logic [WIDTH-1:0] cur_bin_c, prev_bin_c, diff_c;
  logic             one_hot_c, legal_c, accept_c, check_c, lock_hit_c;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Step classification against the last accepted sample
  always_comb begin
    cur_bin_c  = gray2bin(gray_in);
    prev_bin_c = gray2bin(prev_gray);
    diff_c     = gray_in ^ prev_gray;
    one_hot_c  = (diff_c != '0) && ((diff_c & (diff_c - WIDTH'(1))) == '0);
    legal_c    = one_hot_c && (cur_bin_c == prev_bin_c + WIDTH'(1));
    accept_c   = enable && ((state == EMPTY) || (gray_in != prev_gray));
    check_c    = accept_c && (state != EMPTY);
    lock_hit_c = (good_cnt + CNT_W'(1)) == CNT_W'(LOCK_COUNT);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept_c) state_nxt = ACQ;
      ACQ:     if (check_c && legal_c && lock_hit_c) state_nxt = LOCKED;
      LOCKED:  if (check_c && !legal_c) state_nxt = ACQ;
      default: state_nxt = EMPTY;
    endcase
  end

  // Output / datapath next values; pulses default low, everything else holds
  always_comb begin
    bin_out_d   = bin_out;
    bin_valid_d = 1'b0;
    step_err_d  = 1'b0;
    err_count_d = err_count;
    prev_gray_d = prev_gray;
    good_cnt_d  = good_cnt;
    locked_d    = (state_nxt == LOCKED);
    if (accept_c) begin
      bin_out_d   = cur_bin_c;
      bin_valid_d = 1'b1;
      prev_gray_d = gray_in;
      if (state == EMPTY) begin
        good_cnt_d = '0;
      end else if (legal_c) begin
        if (state == ACQ) good_cnt_d = good_cnt + CNT_W'(1);
      end else begin
        step_err_d = 1'b1;
        good_cnt_d = '0;
        if (err_count != '1) err_count_d = err_count + ERR_W'(1);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_out   <= '0;
      bin_valid <= 1'b0;
      locked    <= 1'b0;
      step_err  <= 1'b0;
      err_count <= '0;
      prev_gray <= '0;
      good_cnt  <= '0;
    end else begin
      bin_out   <= bin_out_d;
      bin_valid <= bin_valid_d;
      locked    <= locked_d;
      step_err  <= step_err_d;
      err_count <= err_count_d;
      prev_gray <= prev_gray_d;
      good_cnt  <= good_cnt_d;
    end
  end

endmodule

// File: tb/tb_gray_stream_checker.sv
// Bench for gray_stream_checker: directed scenarios plus random traffic, checked against
// a behavioural stream model; a second instance with ERR_W=2 exercises saturation.
module tb_gray_stream_checker;

  localparam int LOCK = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] gray_in = 8'h00;

  logic [7:0] bin_out_a, bin_out_b;
  logic       bin_valid_a, bin_valid_b, locked_a, locked_b, step_err_a, step_err_b;
  logic [7:0] err_count_a;
  logic [1:0] err_count_b;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  bit         m_empty = 1'b1;
  logic [7:0] m_prev = 8'h00;
  int         m_run = 0;
  bit         m_locked = 1'b0;
  int         m_err = 0;
  logic [7:0] m_bin = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_step = 1'b0;

  always #5 clk = ~clk;

  gray_stream_checker #(.WIDTH(8), .LOCK_COUNT(LOCK), .ERR_W(8)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .gray_in(gray_in),
    .bin_out(bin_out_a), .bin_valid(bin_valid_a), .locked(locked_a),
    .step_err(step_err_a), .err_count(err_count_a)
  );

  gray_stream_checker #(.WIDTH(8), .LOCK_COUNT(LOCK), .ERR_W(2)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .gray_in(gray_in),
    .bin_out(bin_out_b), .bin_valid(bin_valid_b), .locked(locked_b),
    .step_err(step_err_b), .err_count(err_count_b)
  );

  function automatic logic [7:0] to_bin(input logic [7:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3) ^ (g >> 4) ^ (g >> 5) ^ (g >> 6) ^ (g >> 7);
  endfunction

  function automatic logic [7:0] to_gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit e, input logic [7:0] g);
    if (r) begin
      m_empty = 1'b1; m_prev = 8'h00; m_run = 0; m_locked = 1'b0;
      m_err = 0; m_bin = 8'h00; m_valid = 1'b0; m_step = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_step  = 1'b0;
      if (e && (m_empty || g != m_prev)) begin
        m_valid = 1'b1;
        m_bin   = to_bin(g);
        if (!m_empty) begin
          if ($countones(g ^ m_prev) == 1 && to_bin(g) == 8'(to_bin(m_prev) + 8'd1)) begin
            if (!m_locked) begin
              m_run++;
              if (m_run >= LOCK) m_locked = 1'b1;
            end
          end else begin
            m_step = 1'b1; m_err++; m_run = 0; m_locked = 1'b0;
          end
        end
        m_empty = 1'b0;
        m_prev  = g;
      end
    end
  endtask

  task automatic compare_all();
    check("bin_out",    32'(bin_out_a),   32'(m_bin));
    check("bin_valid",  32'(bin_valid_a), 32'(m_valid));
    check("locked",     32'(locked_a),    32'(m_locked));
    check("step_err",   32'(step_err_a),  32'(m_step));
    check("err_count",  32'(err_count_a), (m_err > 255) ? 32'd255 : 32'(m_err));
    check("sat_bin",    32'(bin_out_b),   32'(m_bin));
    check("sat_step",   32'(step_err_b),  32'(m_step));
    check("sat_locked", 32'(locked_b),    32'(m_locked));
    check("sat_err",    32'(err_count_b), (m_err > 3) ? 32'd3 : 32'(m_err));
  endtask

  task automatic step(input bit r, input bit e, input logic [7:0] g);
    reset = r; enable = e; gray_in = g;
    @(posedge clk);
    #1;
    model(r, e, g);
    compare_all();
  endtask

  initial begin
    logic [7:0] cur;
    logic [7:0] g;
    bit         r, e;

    // Reset
    step(1, 1, 8'h5A);
    step(1, 0, 8'h00);
    check("rst_bin", 32'(bin_out_a), 32'd0);
    check("rst_locked", 32'(locked_a), 32'd0);

    // Counting stream from gray 0; lock on gray 0x06 (bin 4)
    for (int b = 0; b <= 10; b++) begin
      step(0, 1, to_gray(8'(b)));
      if (b == 3) check("dir_not_locked_b3", 32'(locked_a), 32'd0);
      if (b == 4) check("dir_locked_b4", 32'(locked_a), 32'd1);
    end

    // Stall for 3 cycles then resume
    for (int i = 0; i < 3; i++) step(0, 0, to_gray(8'd11));
    check("dir_stall_hold", 32'(bin_out_a), 32'd10);
    step(0, 1, to_gray(8'd11));
    step(0, 1, to_gray(8'd12));

    // Forced skip, then clean recovery to lock
    step(0, 1, 8'h02);
    step(0, 1, 8'h07);
    check("dir_skip_bin", 32'(bin_out_a), 32'd5);
    check("dir_skip_err", 32'(step_err_a), 32'd1);
    step(0, 1, 8'h05);
    step(0, 1, 8'h04);
    step(0, 1, 8'h0C);
    step(0, 1, 8'h0D);
    check("dir_relock", 32'(locked_a), 32'd1);

    // Single-bit decrement is illegal
    step(0, 1, 8'h03);
    step(0, 1, 8'h01);
    check("dir_dec_err", 32'(step_err_a), 32'd1);

    // Wrap 255 -> 0 is legal; repeated samples are ignored
    step(0, 1, 8'h80);
    step(0, 1, 8'h00);
    check("dir_wrap_ok", 32'(step_err_a), 32'd0);
    for (int i = 0; i < 5; i++) step(0, 1, 8'h00);
    check("dir_hold_novalid", 32'(bin_valid_a), 32'd0);

    // Five more illegal steps: narrow counter sticks at 3
    for (int i = 0; i < 5; i++) step(0, 1, (i % 2 == 0) ? 8'h03 : 8'h00);
    check("dir_sat", 32'(err_count_b), 32'd3);

    // Lock, then reset while locked, then first sample after reset
    step(1, 0, 8'h00);
    for (int b = 0; b <= 6; b++) step(0, 1, to_gray(8'(b)));
    check("dir_locked_pre_rst", 32'(locked_a), 32'd1);
    step(1, 1, to_gray(8'd7));
    check("dir_rst_locked", 32'(locked_a), 32'd0);
    check("dir_rst_valid", 32'(bin_valid_a), 32'd0);
    step(0, 1, 8'h55);
    check("dir_first_bin", 32'(bin_out_a), 32'h66);
    check("dir_first_valid", 32'(bin_valid_a), 32'd1);
    check("dir_first_noerr", 32'(step_err_a), 32'd0);

    // Random traffic: mostly legal increments, with stalls, holds, jumps and resets
    cur = 8'h66;
    for (int i = 0; i < 600; i++) begin
      int sel;
      r   = ($urandom_range(0, 149) == 0);
      e   = ($urandom_range(0, 3) != 0);
      sel = int'($urandom_range(0, 19));
      if (sel < 15)      g = to_gray(8'(cur + 8'd1));
      else if (sel < 17) g = to_gray(cur);
      else if (sel < 18) g = to_gray(8'(cur - 8'd1));
      else               g = 8'($urandom_range(0, 255));
      step(r, e, g);
      if (r) cur = 8'h00;
      else if (e) cur = to_bin(g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
